// File: rtl/mem_stage_if.sv
// mem_stage_if: M-stage inputs and MEM/WB register outputs of the RV32I
// memory-access stage, bundled so the stage and its driver share one port.
//   master : EX/MEM + hazard-unit side; drives the *M inputs, StallW, FlushW
//            and observes the *W outputs.
//   slave  : the mem_stage itself.
// Signals:
//   RegWriteM, ResultSrcM, MemWriteM, funct3M, ALUResultM, WriteDataM, RdM,
//   PCPlus4M      - instruction currently in MEM
//   StallW, FlushW - MEM/WB register control
//   RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, MisalignW
//                  - registered write-back-bound values
interface mem_stage_if;
    logic        RegWriteM;
    logic        ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        StallW;
    logic        FlushW;

    logic        RegWriteW;
    logic        ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic        MisalignW;

    modport master (
        output RegWriteM, ResultSrcM, MemWriteM, funct3M, ALUResultM,
               WriteDataM, RdM, PCPlus4M, StallW, FlushW,
        input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W,
               RdW, MisalignW
    );

    modport slave (
        input  RegWriteM, ResultSrcM, MemWriteM, funct3M, ALUResultM,
               WriteDataM, RdM, PCPlus4M, StallW, FlushW,
        output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W,
               RdW, MisalignW
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with word-organised data memory and
// the MEM/WB pipeline register.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (clears MEM/WB, blocks stores)
//   bus  - mem_stage_if.slave: M-stage inputs, StallW/FlushW, *W outputs
// Parameter:
//   DEPTH - data-memory size in 32-bit words (power of two, >= 2)
module mem_stage #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] widx;
    logic [1:0]    boff;
    logic          misaligned;
    logic          misalign_m;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;

    // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
    assign widx = bus.ALUResultM[AW+1:2];
    assign boff = bus.ALUResultM[1:0];

    always_comb begin
        misaligned = 1'b0;
        case (bus.funct3M)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = boff[0];
            3'b010:         misaligned = (boff != 2'b00);
            default:        misaligned = 1'b1;
        endcase
    end

    assign misalign_m = (bus.MemWriteM | bus.ResultSrcM) & misaligned;

    // Store lanes: funct3[1:0] gives the access size; replicate the data so
    // each enabled lane just takes its own slice.
    always_comb begin
        be        = '0;
        wdata_rep = bus.WriteDataM;
        case (bus.funct3M[1:0])
            2'b00: wdata_rep = {4{bus.WriteDataM[7:0]}};
            2'b01: wdata_rep = {2{bus.WriteDataM[15:0]}};
            default: wdata_rep = bus.WriteDataM;
        endcase
        if (bus.MemWriteM && !misaligned) begin
            case (bus.funct3M[1:0])
                2'b00:   be[boff] = 1'b1;
                2'b01:   be = {boff[1], boff[1], ~boff[1], ~boff[1]};
                2'b10:   be = '1;
                default: be = '0;
            endcase
        end
    end

    // No reset on the array; writes are simply suppressed while rst is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    assign rd_word  = mem_q[widx];
    assign rd_shift = rd_word >> {boff, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = boff[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        if (!misaligned) begin
            case (bus.funct3M)
                3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
                3'b100:  load_data = {24'h000000, rd_byte};
                3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
                3'b101:  load_data = {16'h0000, rd_half};
                3'b010:  load_data = rd_word;
                default: load_data = '0;
            endcase
        end
    end

    // MEM/WB register
    logic        regwrite_q,  regwrite_d;
    logic        resultsrc_q, resultsrc_d;
    logic [31:0] aluresult_q, aluresult_d;
    logic [31:0] readdata_q,  readdata_d;
    logic [31:0] pcplus4_q,   pcplus4_d;
    logic [4:0]  rd_q,        rd_d;
    logic        misalign_q,  misalign_d;

    always_comb begin
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        aluresult_d = aluresult_q;
        readdata_d  = readdata_q;
        pcplus4_d   = pcplus4_q;
        rd_d        = rd_q;
        misalign_d  = misalign_q;
        if (bus.FlushW) begin
            // Bubble: controls cleared, data fields follow the inputs.
            regwrite_d  = 1'b0;
            resultsrc_d = 1'b0;
            misalign_d  = 1'b0;
            rd_d        = '0;
            aluresult_d = bus.ALUResultM;
            readdata_d  = load_data;
            pcplus4_d   = bus.PCPlus4M;
        end else if (!bus.StallW) begin
            regwrite_d  = bus.RegWriteM & ~misalign_m;
            resultsrc_d = bus.ResultSrcM;
            misalign_d  = misalign_m;
            rd_d        = bus.RdM;
            aluresult_d = bus.ALUResultM;
            readdata_d  = load_data;
            pcplus4_d   = bus.PCPlus4M;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            aluresult_q <= '0;
            readdata_q  <= '0;
            pcplus4_q   <= '0;
            rd_q        <= '0;
            misalign_q  <= 1'b0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            pcplus4_q   <= pcplus4_d;
            rd_q        <= rd_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.RegWriteW  = regwrite_q;
    assign bus.ResultSrcW = resultsrc_q;
    assign bus.ALUResultW = aluresult_q;
    assign bus.ReadDataW  = readdata_q;
    assign bus.PCPlus4W   = pcplus4_q;
    assign bus.RdW        = rd_q;
    assign bus.MisalignW  = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a byte-addressed reference
// model of the memory and MEM/WB register, checked every cycle, plus literal
// expectations for the named scenarios.
module tb_mem_stage;
    localparam int unsigned DEPTH = 1024;

    logic clk;
    logic rst;
    mem_stage_if bus ();

    mem_stage #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as individual bytes keyed by wrapped address.
    logic [7:0] mb [int unsigned];
    logic        e_rw, e_rs, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_pc, e_rdata;
    logic        e_dval, e_rknown;

    initial begin
        e_rw = 0; e_rs = 0; e_mis = 0; e_rd = 0;
        e_alu = 0; e_pc = 0; e_rdata = 0; e_dval = 1; e_rknown = 1;
    end

    function automatic int unsigned acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    task automatic model_step();
        int unsigned sz, ba;
        logic        mis, mism, lk;
        longint      v;
        logic [31:0] lv;
        if (!rst) begin
            e_rw = 0; e_rs = 0; e_mis = 0; e_rd = 0;
            e_alu = 0; e_pc = 0; e_rdata = 0; e_dval = 1; e_rknown = 1;
            return;
        end
        sz   = acc_size(bus.funct3M);
        ba   = bus.ALUResultM % (DEPTH * 4);
        mis  = (sz == 0) || ((ba % sz) != 0);
        mism = (bus.MemWriteM || bus.ResultSrcM) && mis;
        lv   = 0;
        lk   = bus.ResultSrcM;
        if (!mis) begin
            v = 0;
            for (int unsigned i = 0; i < sz; i++) begin
                if (!mb.exists(ba + i)) lk = 0;
                else v = v | (longint'(mb[ba + i]) << (8 * i));
            end
            if (bus.funct3M[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                v = v - (longint'(1) << (8 * sz));
            lv = v[31:0];
        end
        if (bus.FlushW) begin
            e_rw = 0; e_rs = 0; e_mis = 0; e_rd = 0; e_dval = 0; e_rknown = 0;
        end else if (!bus.StallW) begin
            e_rw = bus.RegWriteM && !mism;
            e_rs = bus.ResultSrcM;
            e_mis = mism;
            e_rd = bus.RdM;
            e_alu = bus.ALUResultM;
            e_pc = bus.PCPlus4M;
            e_dval = 1;
            e_rdata = lv;
            e_rknown = lk;
        end
        if (bus.MemWriteM && !mis) begin
            for (int unsigned i = 0; i < sz; i++)
                mb[ba + i] = bus.WriteDataM[8*i +: 8];
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("cyc_RegWriteW", {31'b0, bus.RegWriteW}, {31'b0, e_rw});
        chk("cyc_ResultSrcW", {31'b0, bus.ResultSrcW}, {31'b0, e_rs});
        chk("cyc_MisalignW", {31'b0, bus.MisalignW}, {31'b0, e_mis});
        chk("cyc_RdW", {27'b0, bus.RdW}, {27'b0, e_rd});
        if (e_dval) begin
            chk("cyc_ALUResultW", bus.ALUResultW, e_alu);
            chk("cyc_PCPlus4W", bus.PCPlus4W, e_pc);
        end
        if (e_rknown) chk("cyc_ReadDataW", bus.ReadDataW, e_rdata);
    end

    logic [31:0] pc_ctr = 32'h100;

    task automatic set_in(input logic rw, input logic rs, input logic mw,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic st, input logic fl);
        bus.RegWriteM  = rw;
        bus.ResultSrcM = rs;
        bus.MemWriteM  = mw;
        bus.funct3M    = f3;
        bus.ALUResultM = a;
        bus.WriteDataM = wd;
        bus.RdM        = rd;
        bus.PCPlus4M   = pc_ctr;
        bus.StallW     = st;
        bus.FlushW     = fl;
        pc_ctr         = pc_ctr + 4;
    endtask

    task automatic op(input logic rw, input logic rs, input logic mw,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd,
                      input logic st, input logic fl);
        @(negedge clk);
        set_in(rw, rs, mw, f3, a, wd, rd, st, fl);
        @(posedge clk);
        #2;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_RegWriteW"}, {31'b0, bus.RegWriteW}, 32'h0);
        chk({tag, "_ResultSrcW"}, {31'b0, bus.ResultSrcW}, 32'h0);
        chk({tag, "_MisalignW"}, {31'b0, bus.MisalignW}, 32'h0);
        chk({tag, "_RdW"}, {27'b0, bus.RdW}, 32'h0);
        chk({tag, "_ALUResultW"}, bus.ALUResultW, 32'h0);
        chk({tag, "_ReadDataW"}, bus.ReadDataW, 32'h0);
        chk({tag, "_PCPlus4W"}, bus.PCPlus4W, 32'h0);
    endtask

    initial begin
        // Reset held low with active inputs; checked before any clock edge.
        rst = 1'b0;
        set_in(1, 1, 1, 3'b010, 32'h10, 32'hFFFF_FFFF, 5'd5, 0, 0);
        #1;
        all_zero("rst_t0");
        repeat (2) @(posedge clk);
        #2;
        all_zero("rst_clk");
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);

        op(1, 0, 0, 3'b000, 32'h10, 32'h0, 5'd5, 0, 0);
        chk("first_RegWriteW", {31'b0, bus.RegWriteW}, 32'h1);
        chk("first_RdW", {27'b0, bus.RdW}, 32'h5);
        chk("first_ALUResultW", bus.ALUResultW, 32'h10);

        // Byte/halfword stores and loads
        op(0, 0, 1, 3'b010, 32'h20, 32'h1122_3344, 5'd0, 0, 0);
        op(0, 0, 1, 3'b000, 32'h21, 32'h0000_00AA, 5'd0, 0, 0);
        op(1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd3, 0, 0);
        chk("lw20", bus.ReadDataW, 32'h1122_AA44);
        op(1, 1, 0, 3'b000, 32'h21, 32'h0, 5'd3, 0, 0);
        chk("lb21", bus.ReadDataW, 32'hFFFF_FFAA);
        op(1, 1, 0, 3'b100, 32'h21, 32'h0, 5'd3, 0, 0);
        chk("lbu21", bus.ReadDataW, 32'h0000_00AA);
        op(1, 1, 0, 3'b001, 32'h22, 32'h0, 5'd3, 0, 0);
        chk("lh22", bus.ReadDataW, 32'h0000_1122);
        op(0, 0, 1, 3'b001, 32'h22, 32'h0000_8001, 5'd0, 0, 0);
        op(1, 1, 0, 3'b001, 32'h22, 32'h0, 5'd3, 0, 0);
        chk("lh22_neg", bus.ReadDataW, 32'hFFFF_8001);
        op(1, 1, 0, 3'b101, 32'h22, 32'h0, 5'd3, 0, 0);
        chk("lhu22", bus.ReadDataW, 32'h0000_8001);

        // Misaligned store and loads
        op(0, 0, 1, 3'b010, 32'h24, 32'h5566_7788, 5'd0, 0, 0);
        op(1, 0, 1, 3'b010, 32'h25, 32'hCAFE_BABE, 5'd6, 0, 0);
        chk("sw25_MisalignW", {31'b0, bus.MisalignW}, 32'h1);
        chk("sw25_RegWriteW", {31'b0, bus.RegWriteW}, 32'h0);
        op(1, 1, 0, 3'b010, 32'h24, 32'h0, 5'd3, 0, 0);
        chk("lw24_unchanged", bus.ReadDataW, 32'h5566_7788);
        op(1, 1, 0, 3'b001, 32'h23, 32'h0, 5'd8, 0, 0);
        chk("lh23_ReadDataW", bus.ReadDataW, 32'h0);
        chk("lh23_RegWriteW", {31'b0, bus.RegWriteW}, 32'h0);
        chk("lh23_MisalignW", {31'b0, bus.MisalignW}, 32'h1);
        op(1, 1, 0, 3'b011, 32'h24, 32'h0, 5'd8, 0, 0);
        chk("f3_011_MisalignW", {31'b0, bus.MisalignW}, 32'h1);
        op(1, 0, 0, 3'b011, 32'h24, 32'h0, 5'd8, 0, 0);
        chk("f3_011_alu_MisalignW", {31'b0, bus.MisalignW}, 32'h0);
        chk("f3_011_alu_RegWriteW", {31'b0, bus.RegWriteW}, 32'h1);

        // Stall holds, flush wins over stall
        op(1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd7, 0, 0);
        chk("pre_stall_ReadDataW", bus.ReadDataW, 32'h8001_AA44);
        for (int i = 0; i < 2; i++) begin
            op(1, 1, 0, 3'b010, 32'h24, 32'h0, 5'd9, 1, 0);
            chk("stall_RdW", {27'b0, bus.RdW}, 32'h7);
            chk("stall_ReadDataW", bus.ReadDataW, 32'h8001_AA44);
        end
        op(1, 0, 0, 3'b000, 32'h30, 32'h0, 5'd9, 1, 1);
        chk("flush_RegWriteW", {31'b0, bus.RegWriteW}, 32'h0);
        chk("flush_RdW", {27'b0, bus.RdW}, 32'h0);

        // Address wrap
        op(0, 0, 1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 5'd0, 0, 0);
        op(1, 1, 0, 3'b010, 32'h0, 32'h0, 5'd10, 0, 0);
        chk("wrap_lw0", bus.ReadDataW, 32'hDEAD_BEEF);

        // Back-to-back store then load
        op(0, 0, 1, 3'b010, 32'h40, 32'h0000_0005, 5'd0, 0, 0);
        op(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd11, 0, 0);
        chk("b2b_lw40", bus.ReadDataW, 32'h0000_0005);

        // Stores proceed under stall and under flush
        op(0, 0, 1, 3'b010, 32'h44, 32'h0000_0099, 5'd0, 1, 0);
        op(1, 1, 0, 3'b010, 32'h44, 32'h0, 5'd12, 0, 0);
        chk("stall_store", bus.ReadDataW, 32'h0000_0099);
        op(0, 0, 1, 3'b010, 32'h48, 32'h0000_0042, 5'd0, 0, 1);
        op(1, 1, 0, 3'b010, 32'h48, 32'h0, 5'd13, 0, 0);
        chk("flush_store", bus.ReadDataW, 32'h0000_0042);

        // Reset asserted mid-store: outputs clear at once, store is lost
        op(0, 0, 1, 3'b010, 32'h80, 32'h0000_1234, 5'd0, 0, 0);
        @(negedge clk);
        set_in(1, 0, 1, 3'b010, 32'h80, 32'h0000_0077, 5'd4, 0, 0);
        rst = 1'b0;
        #1;
        all_zero("async_rst");
        @(posedge clk);
        #2;
        all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        op(1, 1, 0, 3'b010, 32'h80, 32'h0, 5'd14, 0, 0);
        chk("rst_store_lost", bus.ReadDataW, 32'h0000_1234);

        @(negedge clk);
        set_in(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
